// File: rtl/fp_pkg.sv
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared flag encodings, FSM states and field helpers for the
//            floating-point datapath blocks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp_pkg;

    localparam logic [1:0] FLAG_OK  = 2'b00;
    localparam logic [1:0] FLAG_OVF = 2'b01;
    localparam logic [1:0] FLAG_UNF = 2'b10;
    localparam logic [1:0] FLAG_ABN = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ALIGN = 3'd2,
        ADD   = 3'd3,
        NORM  = 3'd4,
        ROUND = 3'd5,
        DONE  = 3'd6
    } state_t;

    function automatic int fp_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    // {carry, hidden, fraction, guard, round, sticky}
    function automatic int fp_work_w(input int man_w);
        return man_w + 5;
    endfunction

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_W     = fp_word_w(DEF_EXP_W, DEF_MAN_W);
    localparam int DEF_WM    = fp_work_w(DEF_MAN_W);

    // Constructors return a 64-bit container; callers size-cast to their word.
    function automatic logic [63:0] fp_nan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_round_pack.sv
// ============================================================================
// Module   : fp_round_pack
// Brief    : Combinational rounding, overflow detect and field packing.
//            FP_ADDSUB_RNE_EN selects round-to-nearest-even, else truncate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
)(
    input  logic                 sign,
    input  logic [EXP_W:0]       exp,
    input  logic [MAN_W+3:0]     man,
    output logic [EXP_W+MAN_W:0] z,
    output logic [1:0]           flags
);
    localparam int W = fp_word_w(EXP_W, MAN_W);
    localparam logic [W-1:0]     c_inf     = W'(fp_inf(EXP_W, MAN_W));
    localparam logic [EXP_W+1:0] c_exp_max = {2'b00, {EXP_W{1'b1}}};

    logic             w_inc;
    logic [MAN_W+1:0] w_sum;
    logic [EXP_W+1:0] w_exp;
    logic [MAN_W-1:0] w_frac;

`ifdef FP_ADDSUB_RNE_EN
    assign w_inc = man[2] & (man[1] | man[0] | man[3]);
`else
    logic w_unused_grs;
    assign w_unused_grs = ^man[2:0];
    assign w_inc        = 1'b0;
`endif

    // A rounding carry out of the hidden bit renormalises by one place.
    assign w_sum  = {1'b0, man[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    assign w_exp  = {1'b0, exp} + {{(EXP_W+1){1'b0}}, w_sum[MAN_W+1]};
    assign w_frac = w_sum[MAN_W+1] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];

    always_comb begin
        z     = {sign, w_exp[EXP_W-1:0], w_frac};
        flags = FLAG_OK;
        if (w_exp >= c_exp_max) begin
            z     = {sign, c_inf[W-2:0]};
            flags = FLAG_OVF;
        end else if (w_exp == '0) begin
            z     = {sign, {(W-1){1'b0}}};
            flags = FLAG_UNF;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_addsub_seq.sv
// ============================================================================
// Module   : fp_addsub_seq
// Brief    : Multi-cycle parametrised floating-point adder/subtractor with
//            valid/ready handshakes. FP_ADDSUB_RNE_EN enables RNE rounding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_addsub_seq
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
)(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] z,
    output logic [1:0]           flags
);
    localparam int W  = fp_word_w(EXP_W, MAN_W);
    localparam int WM = fp_work_w(MAN_W);
    localparam logic [W-1:0]   c_nan   = W'(fp_nan(EXP_W, MAN_W));
    localparam logic [EXP_W:0] c_e_one = {{EXP_W{1'b0}}, 1'b1};

    state_t r_state, w_next;

    logic             r_sa, r_sb, r_sign;
    logic [EXP_W-1:0] r_ea, r_eb;
    logic [MAN_W-1:0] r_fa, r_fb;
    logic [WM-1:0]    r_ma, r_mb, r_m;
    logic [EXP_W:0]   r_e;
    logic [W-1:0]     r_z;
    logic [1:0]       r_flags;

    logic             w_a_zero, w_b_zero, w_a_abn, w_b_abn;
    logic             w_a_small, w_align_done, w_a_ge, w_sign;
    logic [WM-1:0]    w_small_m, w_small_shr, w_sum;
    logic [EXP_W-1:0] w_big_e;
    logic [W-1:0]     w_rz;
    logic [1:0]       w_rflags;

    assign w_a_zero = (r_ea == '0) && (r_fa == '0);
    assign w_b_zero = (r_eb == '0) && (r_fb == '0);
    assign w_a_abn  = (&r_ea) || ((r_ea == '0) && (r_fa != '0));
    assign w_b_abn  = (&r_eb) || ((r_eb == '0) && (r_fb != '0));

    // Alignment stops early once the smaller operand has collapsed into sticky.
    assign w_a_small    = r_ea < r_eb;
    assign w_small_m    = w_a_small ? r_ma : r_mb;
    assign w_small_shr  = {1'b0, w_small_m[WM-1:2], |w_small_m[1:0]};
    assign w_align_done = (r_ea == r_eb) || (w_small_m[WM-1:1] == '0);
    assign w_big_e      = w_a_small ? r_eb : r_ea;
    assign w_a_ge       = r_ma >= r_mb;

    always_comb begin
        w_sum  = r_ma + r_mb;
        w_sign = r_sa;
        if (r_sa != r_sb) begin
            if (w_a_ge) begin
                w_sum = r_ma - r_mb;
            end else begin
                w_sum  = r_mb - r_ma;
                w_sign = r_sb;
            end
        end
    end

    fp_round_pack #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign  (r_sign),
        .exp   (r_e),
        .man   (r_m[WM-2:0]),
        .z     (w_rz),
        .flags (w_rflags)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = CHECK;
            CHECK:   w_next = (w_a_abn || w_b_abn || w_a_zero || w_b_zero) ? DONE : ALIGN;
            ALIGN:   if (w_align_done) w_next = ADD;
            ADD:     w_next = (w_sum == '0) ? DONE : NORM;
            NORM: begin
                if (r_m[WM-1] || r_m[WM-2]) w_next = ROUND;
                else if (r_e == c_e_one)    w_next = DONE;
            end
            ROUND:   w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Working datapath; contents are don't-care outside an active operation.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: if (in_valid) begin
                {r_sa, r_ea, r_fa} <= a;
                {r_sb, r_eb, r_fb} <= b ^ {op, {(W-1){1'b0}}};
            end
            CHECK: begin
                r_ma <= {2'b01, r_fa, 3'b000};
                r_mb <= {2'b01, r_fb, 3'b000};
            end
            ALIGN: if (!w_align_done) begin
                if (w_a_small) begin
                    r_ma <= w_small_shr;
                    r_ea <= r_ea + 1'b1;
                end else begin
                    r_mb <= w_small_shr;
                    r_eb <= r_eb + 1'b1;
                end
            end
            ADD: begin
                r_m    <= w_sum;
                r_e    <= {1'b0, w_big_e};
                r_sign <= w_sign;
            end
            NORM: begin
                if (r_m[WM-1]) begin
                    r_m <= {1'b0, r_m[WM-1:2], |r_m[1:0]};
                    r_e <= r_e + 1'b1;
                end else if (!r_m[WM-2] && (r_e != c_e_one)) begin
                    r_m <= {r_m[WM-2:0], 1'b0};
                    r_e <= r_e - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_z     <= '0;
            r_flags <= FLAG_OK;
        end else begin
            case (r_state)
                CHECK: begin
                    if (w_a_abn || w_b_abn) begin
                        r_z     <= c_nan;
                        r_flags <= FLAG_ABN;
                    end else if (w_a_zero && w_b_zero) begin
                        r_z     <= {r_sa & r_sb, {(W-1){1'b0}}};
                        r_flags <= FLAG_OK;
                    end else if (w_a_zero) begin
                        r_z     <= {r_sb, r_eb, r_fb};
                        r_flags <= FLAG_OK;
                    end else if (w_b_zero) begin
                        r_z     <= {r_sa, r_ea, r_fa};
                        r_flags <= FLAG_OK;
                    end
                end
                ADD: if (w_sum == '0) begin
                    r_z     <= '0;
                    r_flags <= FLAG_OK;
                end
                NORM: if (!r_m[WM-1] && !r_m[WM-2] && (r_e == c_e_one)) begin
                    r_z     <= {r_sign, {(W-1){1'b0}}};
                    r_flags <= FLAG_UNF;
                end
                ROUND: begin
                    r_z     <= w_rz;
                    r_flags <= w_rflags;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign z         = r_z;
    assign flags     = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
// ============================================================================
// Module   : tb_fp_addsub_seq
// Brief    : Self-checking bench for fp_addsub_seq (single precision) with an
//            exact-arithmetic reference model. Honours FP_ADDSUB_RNE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_addsub_seq;

    localparam int LAT_MAX = 1 + 1 + (23 + 4) + 1 + (23 + 3) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid;
    logic [31:0] z;
    logic [1:0]  flags;

    int n_checks = 0;
    int n_fail   = 0;

    fp_addsub_seq #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Exact result from integer arithmetic, then rounded and range-checked.
    task automatic model(input logic [31:0] x, input logic [31:0] y0, input logic o,
                         output logic [31:0] rz, output logic [1:0] rf);
        logic [31:0]  y;
        logic         sx, sy, rs;
        int           ex, ey, emin, p, be;
        logic [299:0] mx, my, mag;
        logic [24:0]  mant;
        logic         rup;
        y  = y0 ^ {o, 31'd0};
        sx = x[31];
        sy = y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        rz = '0;
        rf = 2'b00;
        if (ex == 255 || ey == 255 || (ex == 0 && x[22:0] != 0) || (ey == 0 && y[22:0] != 0)) begin
            rz = 32'h7FC00000;
            rf = 2'b11;
        end else if (x[30:0] == 0 && y[30:0] == 0) begin
            rz = {sx & sy, 31'd0};
        end else if (x[30:0] == 0) begin
            rz = y;
        end else if (y[30:0] == 0) begin
            rz = x;
        end else begin
            emin = (ex < ey) ? ex : ey;
            mx = 300'({1'b1, x[22:0]}) << (ex - emin);
            my = 300'({1'b1, y[22:0]}) << (ey - emin);
            if (sx == sy) begin
                mag = mx + my; rs = sx;
            end else if (mx >= my) begin
                mag = mx - my; rs = sx;
            end else begin
                mag = my - mx; rs = sy;
            end
            if (mag != 0) begin
                p = 0;
                for (int i = 0; i < 300; i++) if (mag[i]) p = i;
                be = p + emin - 23;
                if (be < 1) begin
                    rz = {rs, 31'd0};
                    rf = 2'b10;
                end else begin
                    if (p >= 23) mant = 25'(mag >> (p - 23));
                    else         mant = 25'(mag << (23 - p));
                    rup = 1'b0;
`ifdef FP_ADDSUB_RNE_EN
                    if (p >= 24)
                        rup = mag[p-24] && (((mag & ((300'd1 << (p - 24)) - 300'd1)) != 0) || mant[0]);
`endif
                    mant = mant + 25'(rup);
                    if (mant[24]) begin
                        mant = mant >> 1;
                        be++;
                    end
                    if (be >= 255) begin
                        rz = {rs, 8'hFF, 23'd0};
                        rf = 2'b01;
                    end else begin
                        rz = {rs, 8'(be), mant[22:0]};
                    end
                end
            end
        end
    endtask

    task automatic do_op(input string tag, input logic [31:0] ta, input logic [31:0] tb2,
                         input logic top, input logic [31:0] ez, input logic [1:0] ef,
                         input int stall);
        int cyc;
        @(negedge clk);
        check({tag, ":in_ready"}, 64'(in_ready), 64'd1);
        a = ta; b = tb2; op = top; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, ":out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ":latency_ok"}, 64'(cyc + 1 <= LAT_MAX), 64'd1);
        check({tag, ":z"}, 64'(z), 64'(ez));
        check({tag, ":flags"}, 64'(flags), 64'(ef));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ":hold_z"}, 64'(z), 64'(ez));
            check({tag, ":hold_flags"}, 64'(flags), 64'(ef));
            check({tag, ":hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ":hold_out_valid"}, 64'(out_valid), 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ":released"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb, ez, tmp;
        logic [1:0]  ef;
        logic        rop;
        int          k, ea, eb;

        repeat (3) @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_z", 64'(z), 64'd0);
        check("reset_flags", 64'(flags), 64'd0);
        rst = 1'b1;

        do_op("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 2'b00, 0);
        do_op("sub_eq",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 2'b00, 0);
        do_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 2'b01, 0);
        do_op("unf",       32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 2'b10, 0);
        do_op("nan_in",    32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11, 0);
        do_op("denorm_in", 32'h00000001, 32'h3F800000, 1'b0, 32'h7FC00000, 2'b11, 0);
        do_op("sub_neg",   32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 2'b00, 0);
        do_op("zero_b",    32'h40490FDB, 32'h80000000, 1'b0, 32'h40490FDB, 2'b00, 0);
        do_op("both_zero", 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 2'b00, 0);
`ifdef FP_ADDSUB_RNE_EN
        do_op("round_bp",  32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 2'b00, 10);
`else
        do_op("round_bp",  32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800000, 2'b00, 10);
`endif

        // Reset while the operation is still aligning.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h33C00000; op = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_z", 64'(z), 64'd0);
        check("midrst_flags", 64'(flags), 64'd0);
        do_op("after_rst", 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 2'b00, 0);

        for (int n = 0; n < 300; n++) begin
            k  = int'($urandom_range(0, 15));
            ea = int'($urandom_range(1, 254));
            eb = ea + int'($urandom_range(0, 6)) - 3;
            if (k == 2 || k == 3) begin
                ea = 254;
                eb = int'($urandom_range(252, 254));
            end
            if (k == 4 || k == 5) begin
                ea = int'($urandom_range(1, 3));
                eb = int'($urandom_range(1, 3));
            end
            if (k >= 12) eb = int'($urandom_range(1, 254));
            if (eb < 1)   eb = 1;
            if (eb > 254) eb = 254;
            ra = {1'($urandom), 8'(ea), 23'($urandom)};
            rb = {1'($urandom), 8'(eb), 23'($urandom)};
            if (k >= 6 && k <= 10) rb[22:10] = ra[22:10];
            if (k == 0) rb[30:0] = '0;
            if (k == 1) rb[30:23] = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            if ($urandom_range(0, 1) == 1) begin
                tmp = ra; ra = rb; rb = tmp;
            end
            rop = 1'($urandom);
            model(ra, rb, rop, ez, ef);
            do_op("rand", ra, rb, rop, ez, ef, int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
- Parametrised, multi-cycle IEEE-754-style floating-point adder/subtractor; generation-2 replacement for the fixed single-precision adder.
- Operand widths are set by exponent/mantissa parameters. Adds an add/sub opcode, valid/ready handshakes on both sides, guard/round/sticky tracking and canonical special-value outputs.
- Sits between operand-issue logic and the result writeback stage of the datapath.

Parameters:
- EXP_W, 8, exponent field width (>=4).
- MAN_W, 23, stored fraction width (>=4); total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept; high only in IDLE.
- a  in  W  operand A (sign, exponent, fraction).
- b  in  W  operand B.
- op  in  1  0 = a+b, 1 = a-b (sign of b inverted at capture).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  W  result.
- flags  out  2  00 ok, 01 overflow, 10 underflow, 11 abnormal input.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, in_ready=1, out_valid=0, z=0, flags=00. Any in-flight operation is discarded, no output.
- Transfers: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
- IDLE: on input transfer, register a, b^{op<<(W-1)} and unpack; go to CHECK. in_ready=0 in all other states.
- CHECK:
  - Either exponent all-ones, or exponent 0 with nonzero fraction -> z = {0, all-ones exp, 1, zeros} (canonical NaN), flags=11 -> DONE.
  - One operand zero -> z = other operand; both zero -> sign = AND of signs; flags=00 -> DONE.
  - Otherwise -> ALIGN.
- Working mantissa: {carry, hidden 1, MAN_W frac, G, R, S}, i.e. MAN_W+5 bits.
- ALIGN:
  - Each cycle, shift the smaller-exponent mantissa right 1 and increment its exponent; bits shifted past R OR into S.
  - When exponents equal, or the shifted mantissa has become only sticky, -> ADD.
  - At most MAN_W+4 cycles.
- ADD:
  - Same signs: sum, sign = sign of a.
  - Otherwise subtract smaller magnitude from larger, sign of larger.
  - Exact zero -> z = +0, flags=00 -> DONE. Otherwise -> NORM.
- NORM:
  - Carry set: shift right 1 (LSB ORed into S), exponent+1 -> ROUND.
  - Hidden bit 0: shift left 1, exponent-1, stay.
  - Otherwise -> ROUND.
  - Exponent reaching 0 during left shifts -> underflow.
- ROUND: apply rounding (see Optional Feature). Rounding carry renormalises once (exponent+1).
- Overflow: final exponent == all-ones -> z = ±inf (zero fraction), flags=01.
- Underflow: exponent <1 -> z = signed zero, flags=10 (flush, no subnormal output).
- DONE: out_valid=1, z/flags held stable while out_ready=0. On output transfer -> IDLE. No new input is accepted in the same cycle.
- Throughput: one operation in flight.
- Latency bound: 1 + 1 + (MAN_W+4) + 1 + (MAN_W+3) + 1 cycles from input transfer to out_valid.

Optional Feature:
- FP_ADDSUB_RNE_EN defined: ROUND performs round-to-nearest-even. Increment if G&&(R||S||LSB).
- Undefined: ROUND truncates (G/R/S discarded); ROUND state is still one cycle, so the latency is identical.

Decomposition:
- Package fp_pkg holds:
  - flag encodings FLAG_OK/OVF/UNF/ABN;
  - state enum IDLE/CHECK/ALIGN/ADD/NORM/ROUND/DONE;
  - width helper localparams (W, working mantissa width);
  - canonical NaN/inf constructors as parametrised functions.
- One sub-module fits: fp_round_pack (combinational RNE/truncate plus overflow detect and field packing), reusable by future mul/div blocks.

Test Plan (EXP_W=8, MAN_W=23):
- a=0x3F800000, b=0x40000000, op=0 -> z=0x40400000, flags=00.
- a=0x3F800000, b=0x3F800000, op=1 -> z=0x00000000, flags=00.
- a=b=0x7F7FFFFF, op=0 -> z=0x7F800000, flags=01. a=0x00800000, b=0x00800001, op=1 -> z=0x80000000, flags=10.
- a=0x7FC00000, b=0x3F800000 -> z=0x7FC00000, flags=11. a=0x00000001 -> same output, flags=11.
- a=0x3F800000, b=0x33C00000, op=0 -> z=0x3F800001 with FP_ADDSUB_RNE_EN; z=0x3F800000 without.
- Backpressure/reset:
  - Hold out_ready=0 for 10 cycles: z/flags stable, in_ready=0.
  - Assert rst=0 mid-ALIGN: next cycle out_valid=0, in_ready=1, and the next operation's result is correct.
